// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write-side and read-side FIFO pointer blocks.
// The functions work on 32-bit vectors; callers zero-extend and truncate.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits contribute nothing.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < PTR_MAX_W; s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side FIFO bus: producer handshake, synchronized read pointer and status.
interface wptr_full_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic                wovf_clr;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE-1:0] waddr;
  logic                wclken;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                woverflow;

  modport master (
    output winc, wovf_clr, wq2_rptr,
    input  waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
  );

  modport slave (
    input  winc, wovf_clr, wq2_rptr,
    output waddr, wclken, wptr, wfull, walmost_full, wlevel, woverflow
  );
endinterface

// File: rtl/wptr_full.sv
// Write-domain pointer/status block: binary+Gray write pointers, full,
// almost-full, occupancy and sticky overflow against the synchronized read pointer.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input logic       wclk,
  input logic       wrst,
  wptr_full_if.slave bus
);
  localparam int DEPTH = depth_of(ADDRSIZE);
  localparam int PW    = ADDRSIZE + 1;

  if (ADDRSIZE < 2) begin : g_bad_addrsize
    $error("wptr_full: ADDRSIZE must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("wptr_full: AFULL_THRESH must lie in 1..DEPTH");
  end

  logic [PW-1:0] wbin, wbin_next, wgray_next, rbin, level_next, full_gray;
  logic          accept;

  assign accept     = bus.winc & ~bus.wfull;
  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
  assign rbin       = PW'(gray2bin(PTR_MAX_W'(bus.wq2_rptr)));
  assign level_next = wbin_next - rbin;

  // Full when the write pointer has lapped the read pointer exactly once:
  // in Gray code that is the top two bits inverted, the rest equal.
  assign full_gray = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};

  assign bus.waddr  = wbin[ADDRSIZE-1:0];
  assign bus.wclken = accept;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin             <= '0;
      bus.wptr         <= '0;
      bus.wfull        <= 1'b0;
      bus.walmost_full <= 1'b0;
      bus.wlevel       <= '0;
      bus.woverflow    <= 1'b0;
    end else begin
      wbin             <= wbin_next;
      bus.wptr         <= wgray_next;
      bus.wfull        <= (wgray_next == full_gray);
      bus.wlevel       <= level_next;
      bus.walmost_full <= (int'(level_next) >= AFULL_THRESH);
      // Set beats clear so a clear racing a fresh overflow cannot hide it.
      if (bus.winc & bus.wfull) bus.woverflow <= 1'b1;
      else if (bus.wovf_clr)    bus.woverflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Scenario bench for wptr_full; expectations come from a counting model of
// writes and reads (occupancy = writes - reads) kept in the bench.
module tb_wptr_full;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  wptr_full_if #(.ADDRSIZE(AW)) bus ();
  wptr_full #(.ADDRSIZE(AW), .AFULL_THRESH(THR)) dut (.wclk(wclk), .wrst(wrst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: total writes accepted and reads completed since reset.
  int wcount = 0, rcount = 0, m_level = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = (AW + 1)'(n & 31);
    return b ^ (b >> 1);
  endfunction

  task automatic set_r(input int n);
    rcount = n;
    bus.wq2_rptr = gray(n);
  endtask

  task automatic tick();
    bit acc, ovf_set;
    @(posedge wclk);
    if (wrst) begin
      wcount = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      acc     = bus.winc && !m_full;
      ovf_set = bus.winc && m_full;
      if (acc) wcount++;
      m_level = wcount - rcount;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= THR);
      if (ovf_set) m_ovf = 1;
      else if (bus.wovf_clr) m_ovf = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    wrst = 1; bus.winc = 0; bus.wovf_clr = 0; set_r(0);
    tick(); tick();
    wrst = 0;
    n_checks++; if (bus.wptr !== '0) begin n_fail++; $display("FAIL reset_wptr got %0h exp 0", bus.wptr); end
    n_checks++; if (bus.waddr !== '0) begin n_fail++; $display("FAIL reset_waddr got %0h exp 0", bus.waddr); end
    n_checks++; if ({bus.wfull, bus.walmost_full, bus.woverflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.wfull, bus.walmost_full, bus.woverflow}); end
    n_checks++; if (bus.wlevel !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus.wlevel); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      bus.winc = 1; #1;
      n_checks++; if (bus.waddr !== AW'(i)) begin n_fail++; $display("FAIL fill_waddr i=%0d got %0d exp %0d", i, bus.waddr, i); end
      n_checks++; if (bus.wclken !== 1'b1) begin n_fail++; $display("FAIL fill_wclken i=%0d got %b exp 1", i, bus.wclken); end
      tick();
      n_checks++; if (bus.wlevel !== (AW + 1)'(m_level)) begin n_fail++; $display("FAIL fill_level i=%0d got %0d exp %0d", i, bus.wlevel, m_level); end
      n_checks++; if (bus.walmost_full !== m_afull) begin n_fail++; $display("FAIL fill_afull i=%0d got %b exp %b", i, bus.walmost_full, m_afull); end
      n_checks++; if (bus.wfull !== m_full) begin n_fail++; $display("FAIL fill_full i=%0d got %b exp %b", i, bus.wfull, m_full); end
    end
    bus.winc = 0;
    n_checks++; if (bus.wptr !== 5'b11000) begin n_fail++; $display("FAIL fill_final_wptr got %b exp 11000", bus.wptr); end
    n_checks++; if (bus.wlevel !== 5'd16) begin n_fail++; $display("FAIL fill_final_level got %0d exp 16", bus.wlevel); end
  endtask

  task automatic test_overflow();
    bus.winc = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.wclken !== 1'b0) begin n_fail++; $display("FAIL ovf_wclken i=%0d got %b exp 0", i, bus.wclken); end
      tick();
      n_checks++; if (bus.wptr !== 5'b11000) begin n_fail++; $display("FAIL ovf_wptr_hold i=%0d got %b exp 11000", i, bus.wptr); end
      n_checks++; if (bus.woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set i=%0d got %b exp 1", i, bus.woverflow); end
    end
    bus.wovf_clr = 1; tick();
    n_checks++; if (bus.woverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", bus.woverflow); end
    bus.winc = 0; tick();
    bus.wovf_clr = 0;
    n_checks++; if (bus.woverflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", bus.woverflow); end
  endtask

  task automatic test_read_release();
    set_r(1); tick();
    n_checks++; if (bus.wfull !== 1'b0) begin n_fail++; $display("FAIL rel_full got %b exp 0", bus.wfull); end
    n_checks++; if (bus.wlevel !== 5'd15) begin n_fail++; $display("FAIL rel_level got %0d exp 15", bus.wlevel); end
    bus.winc = 1; tick(); bus.winc = 0;
    n_checks++; if (bus.wfull !== 1'b1) begin n_fail++; $display("FAIL rel_refull got %b exp 1", bus.wfull); end
    n_checks++; if (bus.wlevel !== 5'd16) begin n_fail++; $display("FAIL rel_level16 got %0d exp 16", bus.wlevel); end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev;
    int bad_full = 0, bad_level = 0, bad_step = 0;
    set_r(wcount - 2); tick();
    for (int i = 0; i < 40; i++) begin
      prev = bus.wptr;
      bus.winc = 1; set_r(wcount + 1 - 2);
      tick();
      if (bus.wfull !== 1'b0) bad_full++;
      if (bus.wlevel !== 5'd2) bad_level++;
      if ($countones(bus.wptr ^ prev) != 1 || bus.wptr !== gray(wcount)) bad_step++;
    end
    bus.winc = 0;
    n_checks++; if (bad_full != 0) begin n_fail++; $display("FAIL wrap_full got %0d bad cycles exp 0", bad_full); end
    n_checks++; if (bad_level != 0) begin n_fail++; $display("FAIL wrap_level got %0d bad cycles exp 0", bad_level); end
    n_checks++; if (bad_step != 0) begin n_fail++; $display("FAIL wrap_gray_step got %0d bad steps exp 0", bad_step); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      bus.winc     = ($urandom_range(0, 3) != 0);
      bus.wovf_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0 && rcount < wcount) set_r(rcount + 1);
      tick();
      if (bus.waddr !== AW'(wcount & 15) || bus.wptr !== gray(wcount) ||
          bus.wlevel !== (AW + 1)'(m_level) || bus.wfull !== m_full ||
          bus.walmost_full !== m_afull || bus.woverflow !== m_ovf ||
          bus.wclken !== (bus.winc && !m_full)) begin
        bad++;
        if (bad <= 5) $display("FAIL rand_cycle i=%0d got ptr=%b lvl=%0d f=%b af=%b ov=%b exp ptr=%b lvl=%0d f=%b af=%b ov=%b",
          i, bus.wptr, bus.wlevel, bus.wfull, bus.walmost_full, bus.woverflow,
          gray(wcount), m_level, m_full, m_afull, m_ovf);
      end
    end
    bus.winc = 0; bus.wovf_clr = 0;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_total got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_same_edge();
    wrst = 1; set_r(0); tick(); wrst = 0;
    bus.winc = 1;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (bus.wlevel !== 5'd15) begin n_fail++; $display("FAIL same_pre_level got %0d exp 15", bus.wlevel); end
    set_r(1); tick(); bus.winc = 0;
    n_checks++; if (bus.wlevel !== 5'd15) begin n_fail++; $display("FAIL same_level got %0d exp 15", bus.wlevel); end
    n_checks++; if (bus.wfull !== 1'b0) begin n_fail++; $display("FAIL same_full got %b exp 0", bus.wfull); end
  endtask

  task automatic test_reset_mid();
    wrst = 1; set_r(0); tick(); wrst = 0;
    bus.winc = 1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (bus.wlevel !== 5'd10) begin n_fail++; $display("FAIL mid_pre_level got %0d exp 10", bus.wlevel); end
    wrst = 1; tick(); wrst = 0; bus.winc = 0; #1;
    n_checks++; if ({bus.wptr, bus.waddr, bus.wlevel} !== '0) begin
      n_fail++; $display("FAIL mid_ptrs got wptr=%b waddr=%0d lvl=%0d exp 0", bus.wptr, bus.waddr, bus.wlevel); end
    n_checks++; if ({bus.wfull, bus.walmost_full, bus.woverflow, bus.wclken} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_flags got %b exp 0000", {bus.wfull, bus.walmost_full, bus.woverflow, bus.wclken}); end
  endtask

  initial begin
    bus.winc = 0; bus.wovf_clr = 0; bus.wq2_rptr = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_random();
    test_same_edge();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
